// File: rtl/bus_arbiter4_pkg.sv
// Shared arbiter definitions: state encoding, port count and the round-robin
// pick helper reused by the arbiters in this codebase.
package bus_arbiter4_pkg;

  localparam int ARB_PORTS = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Walks ptr+3 down to ptr so the entry nearest ptr is written last and wins.
  function automatic rr_pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    rr_pick_t   res;
    logic [1:0] idx;
    res = '0;
    for (int k = ARB_PORTS - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_arbiter4_rr_priority4.sv
// Combinational 4-way round-robin picker: first set request at or after i_ptr.
module rr_priority4
  import bus_arbiter4_pkg::*;
(
  input  logic [ARB_PORTS-1:0] i_req,
  input  logic [1:0]           i_ptr,
  output logic                 o_found,
  output logic [1:0]           o_idx
);

  rr_pick_t w_pick;

  assign w_pick  = rr_pick(i_req, i_ptr);
  assign o_found = w_pick.found;
  assign o_idx   = w_pick.idx;

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for a shared 4:1 datapath mux with locked bursts and a
// per-tenure beat limit; sel/gnt are registered, out_valid/ack combinational.
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int BEAT_W    = $clog2(MAX_BEATS) + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [ARB_PORTS-1:0] req,
  input  logic [ARB_PORTS-1:0] lock,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [1:0]           sel,
  output logic [ARB_PORTS-1:0] gnt,
  output logic [ARB_PORTS-1:0] ack,
  output logic                 busy
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  arb_state_e           r_state, w_state_nxt;
  logic [1:0]           r_owner, w_owner_nxt;
  logic [1:0]           r_ptr,   w_ptr_nxt;
  logic [BEAT_W-1:0]    r_beats, w_beats_nxt;
  logic [ARB_PORTS-1:0] r_gnt,   w_gnt_nxt;

  logic       w_granted;
  logic       w_owner_req;
  logic       w_xfer;
  logic       w_release;
  logic [1:0] w_pick_ptr;
  logic       w_found;
  logic [1:0] w_win;

  assign w_granted   = (r_state == GRANT);
  assign w_owner_req = req[r_owner];
  assign w_xfer      = w_granted & w_owner_req & out_ready;
  assign w_release   = w_granted &
                       ((w_xfer & (~lock[r_owner] | (r_beats == LAST_BEAT))) | ~w_owner_req);

  // On release the releasing owner drops to lowest priority in the same cycle.
  assign w_pick_ptr = w_granted ? (r_owner + 2'd1) : r_ptr;

  rr_priority4 u_pick (
    .i_req   (req),
    .i_ptr   (w_pick_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_beats_nxt = r_beats;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_win;
          w_beats_nxt = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt   = w_pick_ptr;
          w_beats_nxt = '0;
          if (w_found) begin
            w_owner_nxt = w_win;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_xfer) begin
          w_beats_nxt = r_beats + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_gnt_nxt = (w_state_nxt == GRANT) ? (ARB_PORTS'(1) << w_owner_nxt) : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_beats <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_beats <= w_beats_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  // sel follows the owner register, which holds its value through IDLE.
  assign sel       = r_owner;
  assign gnt       = r_gnt;
  assign busy      = w_granted;
  assign out_valid = w_granted & w_owner_req;
  assign ack       = r_gnt & {ARB_PORTS{w_xfer}};

endmodule

// File: tb/tb_bus_arbiter4.sv
// Randomized bench for bus_arbiter4 against a transaction-level round-robin model.
module tb_bus_arbiter4;

  localparam int MAX_BEATS = 16;

  logic       clock;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [3:0] ack;
  logic       busy;

  int n_checks;
  int n_fail;

  // Reference model: owner (-1 when idle), round-robin start, transfers taken
  // in the current tenure, and the select value shown while idle.
  int m_owner;
  int m_ptr;
  int m_count;
  int m_sel;

  bus_arbiter4 #(.MAX_BEATS(MAX_BEATS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .lock      (lock),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .sel       (sel),
    .gnt       (gnt),
    .ack       (ack),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_count = 0;
    m_sel   = 0;
  endtask

  // Compare the current cycle's outputs, then advance the model past the next edge.
  task automatic check_and_step();
    logic [3:0] e_gnt;
    logic       e_valid;
    logic       xfer;
    bit         rel;
    int         w;
    e_gnt   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e_valid = (m_owner >= 0) && req[m_owner];
    xfer    = e_valid && out_ready;
    check("gnt",       32'(gnt),       32'(e_gnt));
    check("sel",       32'(sel),       32'(m_sel));
    check("busy",      32'(busy),      32'(m_owner >= 0));
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("ack",       32'(ack),       32'(xfer ? e_gnt : 4'b0000));

    if (m_owner < 0) begin
      w = first_from(req, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_count = 0;
        m_sel   = w;
      end
    end else begin
      if (xfer) m_count++;
      rel = (xfer && (!lock[m_owner] || m_count == MAX_BEATS)) || !req[m_owner];
      if (rel) begin
        m_ptr   = (m_owner + 1) % 4;
        m_count = 0;
        w       = first_from(req, m_ptr);
        m_owner = w;
        if (w >= 0) m_sel = w;
      end
    end
  endtask

  function automatic logic [3:0] rand_bits(input int pct);
    logic [3:0] v;
    for (int b = 0; b < 4; b++) v[b] = ($urandom_range(99) < pct);
    return v;
  endfunction

  // Asynchronous reset in the middle of a cycle: outputs must clear before any edge.
  task automatic mid_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_gnt",   32'(gnt),       32'd0);
    check("rst_sel",   32'(sel),       32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ack",   32'(ack),       32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    model_reset();
    req = 4'b0000;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  int ph_req[6]  = '{50, 100, 100, 60, 30, 100};
  int ph_lock[6] = '{30,   0, 100, 50, 80,  60};
  int ph_rdy[6]  = '{70, 100, 100, 10, 50,  40};
  int ph_len[6]  = '{600, 100, 200, 400, 400, 300};

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    req       = 4'b0000;
    lock      = 4'b0000;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_gnt",  32'(gnt),  32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sel",  32'(sel),  32'd0);
    reset_n = 1'b1;

    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < ph_len[p]; c++) begin
        @(negedge clock);
        req       = (ph_req[p] == 100) ? 4'b1111 : rand_bits(ph_req[p]);
        lock      = rand_bits(ph_lock[p]);
        out_ready = ($urandom_range(99) < ph_rdy[p]);
        #1;
        check_and_step();
      end
      mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
Name: bus_arbiter4

Overview:
- Round-robin arbiter that shares one 4:1 datapath multiplexer (WIDTH-bit, 2-bit select) between four requesters feeding one downstream consumer.
- Drives the mux select and a one-hot grant vector, and gates a single valid/ready handshake toward the consumer.
- Supports locked multi-beat bursts, with a beat limit so a locked requester cannot starve the others.
- Sits in front of shared resources in rvsimple, e.g. a unified memory port shared by fetch, load/store and debug.

Parameters:
- MAX_BEATS, 16: maximum transfers per grant tenure before a forced release (must be ≥1).
- BEAT_W, $clog2(MAX_BEATS)+1: beat counter width, derived; do not override.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  4  per-requester request; the requester holds its mux data stable while req=1 and its ack=0.
- lock  in  4  per-requester burst hold; sampled only for the current owner on a transfer cycle.
- out_ready  in  1  downstream consumer ready.
- out_valid  out  1  downstream valid (data is the mux output).
- sel  out  2  mux select = encoded owner.
- gnt  out  4  one-hot grant; all zeros when idle.
- ack  out  4  one-hot transfer strobe = gnt & {4{out_valid & out_ready}}.
- busy  out  1  1 while in GRANT.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, owner=0, ptr=0, beats=0.
  - gnt=0, sel=0, out_valid=0, ack=0, busy=0.
  - Reset mid-burst abandons the burst; no ack is issued in the reset cycle.
- States:
  - IDLE: no owner.
  - GRANT: owner holds the mux.
- Priority:
  - Round-robin starting at ptr; ptr=(last released owner+1) mod 4.
  - Search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If req≠0, pick the winner and register owner, gnt, sel; go to GRANT; beats=0.
  - Latency: req rises at cycle N → gnt/sel valid from cycle N+1.
- GRANT:
  - out_valid = req[owner] (combinational); sel=owner; gnt=onehot(owner).
  - Transfer when out_valid & out_ready. ack[owner]=1 that cycle; beats increments on each transfer.
- Release condition (evaluated in the cycle):
  - (a) transfer with lock[owner]=0; or
  - (b) transfer with beats==MAX_BEATS-1, regardless of lock (forced); or
  - (c) req[owner]=0 with no transfer (requester withdrew).
- On release:
  - ptr ← owner+1 mod 4; beats ← 0.
  - Re-arbitrate in the same cycle over req, using the new ptr, with no bubble.
  - If a winner exists, register the new owner and stay in GRANT; else go to IDLE with gnt=0.
  - The releasing owner has the lowest priority. If it is the only requester it re-wins immediately; after a forced release it gets a fresh beat budget.
- Not released: owner, sel and gnt are unchanged; out_ready=0 stalls indefinitely without losing the grant.
- sel in IDLE holds its last value so the mux output stays stable; consumers must qualify on out_valid.
- ack is never asserted in IDLE or for a non-owner; gnt is always one-hot or zero.
- Requests from non-owners are ignored until release and are not latched. A req that drops before winning is simply lost.
- MAX_BEATS=1: every transfer releases, giving pure per-beat round-robin.
- No combinational path from req or out_ready to sel or gnt; sel and gnt are registered.
- out_valid and ack are combinational from req[owner] and out_ready.

Decomposition:
- Shared package, rvsimple constants/config:
  - arb_state_e enum {IDLE, GRANT}
  - constant ARB_PORTS=4
  - rr_pick function: 4-bit req and 2-bit ptr → found bit + 2-bit index. Reused by future arbiters.
- One natural sub-module: rr_priority4. It is the combinational round-robin picker, instantiated once and fed from the IDLE and release paths.
- The existing 4:1 multiplexer stays external, driven by sel.

Test Plan:
- Reset, then req=4'b0101 at cycle 2 → cycle 3: gnt=0001, sel=0. Transfer with lock=0 → cycle 4: gnt=0100, sel=2. After its transfer: IDLE, gnt=0000.
- Single req[1] held with lock[1]=1, out_ready=1, MAX_BEATS=16 → 16 consecutive acks to requester 1, then forced release. If req[3]=1 is also pending, gnt=1000 on the next cycle.
- Owner 2 granted, out_ready=0 for 10 cycles → out_valid=1, gnt=0100 stable, no ack. out_ready=1 → one ack[2], release.
- Owner 0 granted, req[0] drops with no transfer while req=1110 → release, next owner 1 with ptr=1, no ack issued.
- All four req held, lock=0, out_ready=1 → grant order 0,1,2,3,0,… with one transfer per cycle and no idle bubbles.
- reset_n pulsed low mid-burst (owner 3, beats=5) → outputs go to 0 immediately (asynchronously). After release, ptr=0 and the first grant goes to the lowest-index requester.
